sccb_config_sequencer: RTL and testbench
========================================

SCCB_CONFIG_SEQUENCER -- requirements
Module: sccb_config_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 63, clk_25 cycles per SCCB quarter-bit tick (~99 kHz SIO_C).
REQ-002 SHALL have parameter DEV_ID, default 8'h42, 8-bit SCCB write ID.
REQ-003 SHALL have parameter NUM_REGS, default 75, number of table entries executed.
REQ-004 SHALL have parameter PWR_WAIT, default 25000, clk_25 cycles waited after start before the first transaction.
REQ-005 SHALL have parameter DELAY_CYCLES, default 250000, wait length for a delay entry.
REQ-006 SHALL have parameter GAP_CYCLES, default 64, idle cycles between consecutive transactions.
REQ-007 SHALL have port clk_25, input, 1, the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, a one-cycle pulse that begins a configuration run.
REQ-010 SHALL have port cfg_index, output, 7, table index being fetched.
REQ-011 SHALL have port cfg_data, input, 16, {reg_addr[15:8], reg_val[7:0]} for cfg_index, valid the cycle after cfg_index changes.
REQ-012 SHALL have port sio_c, output, 1, SCCB clock.
REQ-013 SHALL have port sio_d_out, output, 1, SCCB data value.
REQ-014 SHALL have port sio_d_oe, output, 1, 1 = drive sio_d_out, 0 = release (tristated at top level).
REQ-015 SHALL have port busy, output, 1, high from accepted start until done.
REQ-016 SHALL have port done, output, 1, sticky high after the last entry, cleared by start or reset.

Function
REQ-017 SHALL use states IDLE, PWR_WAIT, FETCH, START, BYTE, STOP, GAP, DELAY, DONE.
REQ-018 SHALL accept start only in IDLE or DONE, going to PWR_WAIT with cfg_index=0, busy=1, done=0; start in other states is ignored.
REQ-019 SHALL count PWR_WAIT clk_25 cycles in PWR_WAIT, then go to FETCH.
REQ-020 SHALL in FETCH wait one cycle, then register cfg_data; reg_addr 8'hFF goes to DELAY, otherwise to START.
REQ-021 SHALL free-run a tick counter 0..CLK_DIV-1 in START/BYTE/STOP, reset to 0 on entry to each; a tick is count==CLK_DIV-1.
REQ-022 SHALL in START hold sio_c=1, sio_d_out=1 for one tick, set sio_d_out=0 for one tick, set sio_c=0 for one tick, then go to BYTE.
REQ-023 SHALL in BYTE send three 9-bit phases in order: DEV_ID, reg_addr, reg_val, each MSB first then one don't-care bit.
REQ-024 SHALL give each bit 4 ticks: q0 sio_c=0 and update sio_d; q1 sio_c=0; q2 and q3 sio_c=1.
REQ-025 SHALL set sio_d_oe=0 for the whole 9th bit of every phase, with sio_d_oe=1 at all other times; the ACK level SHALL be ignored.
REQ-026 SHALL use a 2-bit phase counter 0..2 and a 4-bit bit counter 0..8, both zeroed on START entry; after phase 2 bit 8 go to STOP.
REQ-027 SHALL in STOP drive sio_c=0, sio_d_out=0 for one tick, then sio_c=1 for one tick, then sio_d_out=1 for one tick, then go to GAP.
REQ-028 SHALL count GAP_CYCLES cycles in GAP, and DELAY_CYCLES cycles in DELAY with bus idle.
REQ-029 SHALL on leaving GAP or DELAY go to DONE if cfg_index==NUM_REGS-1, else increment cfg_index and go to FETCH.
REQ-030 SHALL in DONE set busy=0, done=1, bus idle, cfg_index holding the last value.
REQ-031 SHALL define bus idle as sio_c=1, sio_d_out=1, sio_d_oe=1, and SHALL hold it in IDLE, PWR_WAIT, FETCH, GAP, DELAY and DONE.
REQ-032 SHALL change sio_d_out only while sio_c=0, except for the START and STOP edges.
REQ-033 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-034 SHALL size counters with $clog2 of their maximum parameter value; NUM_REGS=1 SHALL execute exactly one entry.

Reset
REQ-035 SHALL on reset assertion, at any time including mid-byte, immediately set state=IDLE, bus idle, cfg_index=0, busy=0, done=0, and zero all counters.
REQ-036 SHALL issue no SIO_C edge until a start pulse after reset deasserts.

Verification (CLK_DIV=2, PWR_WAIT=10, GAP_CYCLES=4, DELAY_CYCLES=20, NUM_REGS=3)
REQ-037 SHALL cover: table {12 80, FF 00, 11 01}, start pulse -> 2 transactions (each 27 sio_c rising edges), decoded bytes 42 12 80 then 42 11 01, 20-cycle idle gap between them, done=1.
REQ-038 SHALL cover: bench checker asserts sio_d changes only while sio_c=0 except START/STOP -> no violations over the full run.
REQ-039 SHALL cover: sio_d_oe sampled per bit -> low exactly on bits 9, 18, 27 of each transaction.
REQ-040 SHALL cover: reset asserted at bit 5 of phase 1 -> same-cycle bus idle, busy=0; new start -> sequence restarts at cfg_index=0.
REQ-041 SHALL cover: start pulsed while busy -> ignored, byte stream unchanged; start in DONE -> done clears and the full sequence repeats.
REQ-042 SHALL cover: NUM_REGS=1, entry {3A 04} -> one transaction 42 3A 04, done=1, cfg_index=0.

Source files
------------

// File: rtl/sccb_config_sequencer_if.sv
// Signal bundle between the SCCB configuration sequencer and its register table / camera pins.
// The master side is the sequencer; the slave side is the table ROM, start source and pad logic.
interface sccb_config_sequencer_if;
  logic        start;
  logic [6:0]  cfg_index;
  logic [15:0] cfg_data;
  logic        sio_c;
  logic        sio_d_out;
  logic        sio_d_oe;
  logic        busy;
  logic        done;

  modport master (
    input  start, cfg_data,
    output cfg_index, sio_c, sio_d_out, sio_d_oe, busy, done
  );

  modport slave (
    output start, cfg_data,
    input  cfg_index, sio_c, sio_d_out, sio_d_oe, busy, done
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// Walks a register table after power-up and writes each {addr, value} pair to the camera over SCCB.
// Table entries with address 8'hFF are pauses of DELAY_CYCLES instead of bus writes.
module sccb_config_sequencer #(
  parameter int         CLK_DIV      = 63,
  parameter logic [7:0] DEV_ID       = 8'h42,
  parameter int         NUM_REGS     = 75,
  parameter int         PWR_WAIT     = 25000,
  parameter int         DELAY_CYCLES = 250000,
  parameter int         GAP_CYCLES   = 64
) (
  input  logic                   clk_25,
  input  logic                   reset,
  sccb_config_sequencer_if.master bus
);

  localparam int TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PWR_N    = (PWR_WAIT > 0) ? PWR_WAIT : 1;
  localparam int GAP_N    = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int DLY_N    = (DELAY_CYCLES > 0) ? DELAY_CYCLES : 1;
  localparam int WAIT_MAX = (PWR_N > DLY_N) ? ((PWR_N > GAP_N) ? PWR_N : GAP_N)
                                            : ((DLY_N > GAP_N) ? DLY_N : GAP_N);
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] PWR_LAST  = WAIT_W'(PWR_N - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_N - 1);
  localparam logic [WAIT_W-1:0] DLY_LAST  = WAIT_W'(DLY_N - 1);
  localparam logic [6:0]        LAST_IDX  = 7'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PWR_WAIT, ST_FETCH, ST_START, ST_BYTE, ST_STOP, ST_GAP, ST_DELAY, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [1:0]          quarter_q, quarter_d;
  logic [3:0]          bit_q, bit_d;
  logic [1:0]          phase_q, phase_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fetch_q, fetch_d;
  logic [6:0]          idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sioc_q, sioc_d;
  logic                siod_q, siod_d;
  logic                oe_q, oe_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          val_q, val_d;
  logic [7:0]          cur_byte;
  logic                tick;

  assign tick = (tick_q == TICK_LAST);

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      quarter_q <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      wait_q    <= '0;
      fetch_q   <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sioc_q    <= 1'b1;
      siod_q    <= 1'b1;
      oe_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      fetch_q   <= fetch_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sioc_q    <= sioc_d;
      siod_q    <= siod_d;
      oe_q      <= oe_d;
    end
  end

  // Latched table entry: pure data, no reset needed.
  always_ff @(posedge clk_25) begin
    addr_q <= addr_d;
    val_q  <= val_d;
  end

  always_comb begin
    case (phase_q)
      2'd0:    cur_byte = DEV_ID;
      2'd1:    cur_byte = addr_q;
      default: cur_byte = val_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = '0;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    wait_d    = '0;
    fetch_d   = 1'b0;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    addr_d    = addr_q;
    val_d     = val_q;
    sioc_d    = 1'b1;
    siod_d    = 1'b1;
    oe_d      = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_PWR_WAIT;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      ST_PWR_WAIT: begin
        if (wait_q == PWR_LAST) state_d = ST_FETCH;
        else                    wait_d  = wait_q + 1'b1;
      end

      // First cycle lets the table see the new index; second cycle captures its output.
      ST_FETCH: begin
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          addr_d    = bus.cfg_data[15:8];
          val_d     = bus.cfg_data[7:0];
          quarter_d = '0;
          bit_d     = '0;
          phase_d   = '0;
          state_d   = (bus.cfg_data[15:8] == 8'hFF) ? ST_DELAY : ST_START;
        end
      end

      ST_START: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        if (quarter_q != 2'd0) siod_d = 1'b0;
        if (quarter_q == 2'd2) sioc_d = 1'b0;
        if (tick) begin
          if (quarter_q == 2'd2) begin
            quarter_d = '0;
            state_d   = ST_BYTE;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      // Quarters 0/1 hold SIO_C low, 2/3 high; the 9th bit of each phase is released for ACK.
      ST_BYTE: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        sioc_d = quarter_q[1];
        siod_d = (bit_q == 4'd8) ? 1'b1 : cur_byte[3'd7 - bit_q[2:0]];
        oe_d   = (bit_q != 4'd8);
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d = '0;
              if (phase_q == 2'd2) begin
                phase_d = '0;
                state_d = ST_STOP;
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end

      ST_STOP: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        sioc_d = (quarter_q != 2'd0);
        siod_d = (quarter_q == 2'd2);
        if (tick) begin
          if (quarter_q == 2'd2) begin
            quarter_d = '0;
            state_d   = ST_GAP;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      ST_GAP, ST_DELAY: begin
        if (wait_q == ((state_q == ST_GAP) ? GAP_LAST : DLY_LAST)) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = ST_FETCH;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cfg_index = idx_q;
  assign bus.sio_c     = sioc_q;
  assign bus.sio_d_out = siod_q;
  assign bus.sio_d_oe  = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Scoreboard bench: stimulus pushes expected SCCB bytes, a bus monitor decodes and compares them.
module tb_sccb_config_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sccb_config_sequencer_if ifa ();
  sccb_config_sequencer_if ifb ();

  sccb_config_sequencer #(
    .CLK_DIV(2), .DEV_ID(8'h42), .NUM_REGS(3), .PWR_WAIT(10), .DELAY_CYCLES(20), .GAP_CYCLES(4)
  ) dut_a (
    .clk_25(clk),
    .reset (rst),
    .bus   (ifa)
  );

  sccb_config_sequencer #(
    .CLK_DIV(2), .DEV_ID(8'h42), .NUM_REGS(1), .PWR_WAIT(10), .DELAY_CYCLES(20), .GAP_CYCLES(4)
  ) dut_b (
    .clk_25(clk),
    .reset (rst),
    .bus   (ifb)
  );

  function automatic logic [15:0] rom_a(input logic [6:0] idx);
    case (idx)
      7'd0:    return 16'h1280;
      7'd1:    return 16'hFF00;
      7'd2:    return 16'h1101;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    ifa.cfg_data <= rom_a(ifa.cfg_index);
    ifb.cfg_data <= (ifb.cfg_index == 7'd0) ? 16'h3A04 : 16'h0000;
  end

  typedef struct packed {
    logic       id;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  logic [1:0] sc, sd, soe;
  assign sc  = {ifb.sio_c,     ifa.sio_c};
  assign sd  = {ifb.sio_d_out, ifa.sio_d_out};
  assign soe = {ifb.sio_d_oe,  ifa.sio_d_oe};

  localparam logic [26:0] EXP_OE = ~((27'd1 << 8) | (27'd1 << 17) | (27'd1 << 26));

  int          bitn[2], extra[2], xfers[2], viol[2], re_cnt[2], stop_cyc[2], last_gap[2];
  logic        have_stop[2], in_x[2], prev_c[2], prev_d[2];
  logic [7:0]  shreg[2];
  logic [26:0] oe_vec[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_byte(input int i, input logic [7:0] b);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL byte dut%0d: got %02h, no byte expected", i, b);
    end else begin
      e = exp_q.pop_front();
      if (e.id != 1'(i) || e.b != b) begin
        n_err++;
        $display("FAIL byte dut%0d: got %02h, expected %02h from dut%0d", i, b, e.b, e.id);
      end
    end
  endtask

  // Bus monitor: decodes START/STOP, bit clocks, ACK release and bytes on both instances.
  initial begin
    for (int i = 0; i < 2; i++) begin
      bitn[i] = 0; extra[i] = 0; xfers[i] = 0; viol[i] = 0; re_cnt[i] = 0;
      stop_cyc[i] = 0; last_gap[i] = 0; have_stop[i] = 1'b0; in_x[i] = 1'b0;
      prev_c[i] = 1'b1; prev_d[i] = 1'b1; shreg[i] = '0; oe_vec[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          in_x[i] = 1'b0;
        end else begin
          if (prev_c[i] && sc[i] && (prev_d[i] != sd[i])) begin
            if (!sd[i]) begin
              if (in_x[i]) viol[i]++;
              if (have_stop[i]) last_gap[i] = cyc - stop_cyc[i];
              in_x[i] = 1'b1; bitn[i] = 0; extra[i] = 0; oe_vec[i] = '0;
            end else begin
              if (!in_x[i]) viol[i]++;
              else begin
                check($sformatf("bit_edges dut%0d", i), 32'(bitn[i]), 32'd27);
                check($sformatf("stop_clock dut%0d", i), 32'(extra[i]), 32'd1);
                check($sformatf("ack_release dut%0d", i), 32'(oe_vec[i]), 32'(EXP_OE));
                xfers[i]++;
              end
              in_x[i] = 1'b0; stop_cyc[i] = cyc; have_stop[i] = 1'b1;
            end
          end
          if (!prev_c[i] && sc[i]) begin
            re_cnt[i]++;
            if (!in_x[i]) viol[i]++;
            else if (bitn[i] < 27) begin
              oe_vec[i][5'(bitn[i])] = soe[i];
              if ((bitn[i] % 9) < 8) shreg[i] = {shreg[i][6:0], sd[i]};
              if ((bitn[i] % 9) == 7) compare_byte(i, shreg[i]);
              bitn[i]++;
            end else begin
              extra[i]++;
            end
          end
        end
        prev_c[i] = sc[i];
        prev_d[i] = sd[i];
      end
      if (rst) exp_q.delete();
    end
  end

  task automatic push_bytes(input logic id, input logic [7:0] a, input logic [7:0] v);
    exp_q.push_back('{id: id, b: 8'h42});
    exp_q.push_back('{id: id, b: a});
    exp_q.push_back('{id: id, b: v});
  endtask

  task automatic prep_run(input int i);
    xfers[i] = 0; have_stop[i] = 1'b0; last_gap[i] = 0; bitn[i] = 0;
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) ifa.start = 1'b1;
    else            ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int maxc);
    int k = 0;
    while (k < maxc && !((which == 0) ? ifa.done : ifb.done)) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("done_reached dut%0d", which), 32'((which == 0) ? ifa.done : ifb.done), 32'd1);
  endtask

  task automatic wait_bits(input int target, input int maxc);
    int k = 0;
    while (k < maxc && bitn[0] < target) begin
      @(negedge clk);
      k++;
    end
    check("reach_bit", 32'(bitn[0] >= target), 32'd1);
  endtask

  task automatic check_run_a_end(input string tag);
    check({tag, " done"},      32'(ifa.done),      32'd1);
    check({tag, " busy"},      32'(ifa.busy),      32'd0);
    check({tag, " cfg_index"}, 32'(ifa.cfg_index), 32'd2);
    check({tag, " xfers"},     32'(xfers[0]),      32'd2);
    check({tag, " pending"},   32'(exp_q.size()),  32'd0);
    check({tag, " idle_gap"},  32'(last_gap[0]),   32'd32);
    check({tag, " bus_idle"},  32'({ifa.sio_c, ifa.sio_d_out, ifa.sio_d_oe}), 32'h7);
  endtask

  initial begin
    int re0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy",      32'(ifa.busy),      32'd0);
    check("rst done",      32'(ifa.done),      32'd0);
    check("rst cfg_index", 32'(ifa.cfg_index), 32'd0);
    check("rst bus_idle",  32'({ifa.sio_c, ifa.sio_d_out, ifa.sio_d_oe}), 32'h7);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Run 1: two writes separated by a delay entry.
    prep_run(0);
    push_bytes(1'b0, 8'h12, 8'h80);
    push_bytes(1'b0, 8'h11, 8'h01);
    pulse_start(0);
    check("run1 busy", 32'(ifa.busy), 32'd1);
    check("run1 done", 32'(ifa.done), 32'd0);
    wait_done(0, 3000);
    check_run_a_end("run1");

    // Run 2: restart from DONE, with an extra start pulse mid-byte that must be ignored.
    prep_run(0);
    push_bytes(1'b0, 8'h12, 8'h80);
    push_bytes(1'b0, 8'h11, 8'h01);
    pulse_start(0);
    check("run2 done_cleared", 32'(ifa.done), 32'd0);
    check("run2 busy",         32'(ifa.busy), 32'd1);
    wait_bits(5, 1000);
    pulse_start(0);
    check("busy_start busy",      32'(ifa.busy),      32'd1);
    check("busy_start cfg_index", 32'(ifa.cfg_index), 32'd0);
    wait_done(0, 3000);
    check_run_a_end("run2");

    // Run 3: reset during bit 5 of the register-address phase.
    prep_run(0);
    push_bytes(1'b0, 8'h12, 8'h80);
    push_bytes(1'b0, 8'h11, 8'h01);
    pulse_start(0);
    wait_bits(15, 1000);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst bus_idle",  32'({ifa.sio_c, ifa.sio_d_out, ifa.sio_d_oe}), 32'h7);
    check("midrst busy",      32'(ifa.busy),      32'd0);
    check("midrst done",      32'(ifa.done),      32'd0);
    check("midrst cfg_index", 32'(ifa.cfg_index), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    re0 = re_cnt[0];
    repeat (50) @(negedge clk);
    check("postrst no_sioc_edge", 32'(re_cnt[0] - re0), 32'd0);
    check("postrst busy",         32'(ifa.busy),        32'd0);

    // Run 4: sequence restarts from the first entry after reset.
    prep_run(0);
    push_bytes(1'b0, 8'h12, 8'h80);
    push_bytes(1'b0, 8'h11, 8'h01);
    pulse_start(0);
    check("run4 cfg_index", 32'(ifa.cfg_index), 32'd0);
    check("run4 busy",      32'(ifa.busy),      32'd1);
    wait_done(0, 3000);
    check_run_a_end("run4");

    // Single-entry table.
    prep_run(1);
    push_bytes(1'b1, 8'h3A, 8'h04);
    pulse_start(1);
    check("b busy", 32'(ifb.busy), 32'd1);
    wait_done(1, 2000);
    check("b busy_end",  32'(ifb.busy),      32'd0);
    check("b cfg_index", 32'(ifb.cfg_index), 32'd0);
    check("b xfers",     32'(xfers[1]),      32'd1);
    check("b pending",   32'(exp_q.size()),  32'd0);

    check("a sio_d_while_sioc_high", 32'(viol[0]), 32'd0);
    check("b sio_d_while_sioc_high", 32'(viol[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
